// File: rtl/riscv_params_pkg.sv
// Shared pipeline types for the 5-stage core.
// Operand tags, control bundles and forwarding flags.
package riscv_params_pkg;

    localparam int INSTR_WIDTH = 32;
    localparam int ADDR_WIDTH  = 4;
    localparam int OPC_WIDTH   = 5;

    typedef enum logic [OPC_WIDTH-1:0] {
        OP_ADD  = 5'd0,
        OP_SUB  = 5'd1,
        OP_MUL  = 5'd2,
        OP_DIV  = 5'd3,
        OP_MOD  = 5'd4,
        OP_CMP  = 5'd5,
        OP_AND  = 5'd6,
        OP_OR   = 5'd7,
        OP_NOT  = 5'd8,
        OP_MOV  = 5'd9,
        OP_LSL  = 5'd10,
        OP_LSR  = 5'd11,
        OP_ASR  = 5'd12,
        OP_NOP  = 5'd13,
        OP_LD   = 5'd14,
        OP_ST   = 5'd15,
        OP_BEQ  = 5'd16,
        OP_BGT  = 5'd17,
        OP_B    = 5'd18,
        OP_CALL = 5'd19,
        OP_RET  = 5'd20
    } opcode_e;

    typedef struct packed {
        opcode_e               opcode;
        logic                  I_bit;
        logic [ADDR_WIDTH-1:0] rs1;
        logic [ADDR_WIDTH-1:0] rs2;
        logic [ADDR_WIDTH-1:0] rd;
        logic                  valid;
    } address_reg;

    typedef struct packed {
        logic isSt;
        logic isLd;
        logic isBeq;
        logic isBgt;
        logic isRet;
        logic isImmediate;
        logic isWb;
        logic isUBranch;
        logic isCall;
    } control_signal;

    typedef struct packed {
        address_reg a;
        logic       isWb;
        logic       isLd;
        logic       isSt;
    } stage_tag;

    typedef struct packed {
        logic                   mem_exec_rs1_conflict;
        logic                   mem_exec_rs2_conflict;
        logic                   wb_exec_rs1_conflict;
        logic                   wb_exec_rs2_conflict;
        logic                   wb_mem_rs1_conflict;
        logic                   wb_mem_rs2_conflict;
        logic                   wb_dd_rs1_conflict;
        logic                   wb_dd_rs2_conflict;
        logic                   ld_use_conflict;
        logic [INSTR_WIDTH-1:0] mem_fw_result;
        logic [INSTR_WIDTH-1:0] wb_fw_result;
    } fw_sig;

    function automatic logic reads_rs1(address_reg a);
        return a.valid && !(a.opcode inside {
            OP_NOP, OP_MOV, OP_NOT, OP_B,
            OP_BEQ, OP_BGT, OP_CALL});
    endfunction

    function automatic logic reads_rs2(address_reg a);
        return a.valid && !a.I_bit && (a.opcode inside {
            OP_ADD, OP_SUB, OP_MUL, OP_DIV, OP_MOD,
            OP_CMP, OP_AND, OP_OR, OP_LSL, OP_LSR,
            OP_ASR});
    endfunction

    function automatic logic writes_rd(stage_tag t);
        return t.a.valid && t.isWb;
    endfunction

endpackage

// File: rtl/riscv_tag_stage.sv
// One slot of the EX/MA/RW operand-tag pipeline.
// A bubble loads an all-zero (invalid) tag.
module riscv_tag_stage
    import riscv_params_pkg::*;
(
    input  logic     clk,
    input  logic     rst_n,
    input  logic     bubble,
    input  stage_tag d,
    output stage_tag q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (bubble) begin
            q <= '0;
        end else begin
            q <= d;
        end
    end

endmodule

// File: rtl/riscv_hazard_fw_unit.sv
// Operand hazard detection and forwarding control.
// Tracks EX/MA/RW tags and drives stall/flush for IF/OF.
module riscv_hazard_fw_unit
    import riscv_params_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst_n,
    input  address_reg             of_addr,
    input  control_signal          of_ctrl,
    input  logic                   ex_branch_taken,
    input  logic [INSTR_WIDTH-1:0] ma_result,
    input  logic [INSTR_WIDTH-1:0] rw_result,
    output fw_sig                  fw,
    output logic                   stall_if,
    output logic                   stall_of,
    output logic                   flush_of,
    output logic                   ex_bubble
);

    stage_tag of_t;
    stage_tag ex_t;
    stage_tag ma_t;
    stage_tag rw_t;

    logic ma_rs1_cov;
    logic ma_wr;
    logic rw_wr;
    logic mem1;
    logic mem2;
    logic wb1;
    logic wb2;
    logic wbm1;
    logic wbm2;
    logic dd1;
    logic dd2;
    logic ld_hit;
    logic unused_bits;

    assign of_t = '{
        a:    of_addr,
        isWb: of_ctrl.isWb,
        isLd: of_ctrl.isLd,
        isSt: of_ctrl.isSt
    };

    assign unused_bits = ^{of_ctrl, rw_t};

    riscv_tag_stage u_ex (
        .clk    (clk),
        .rst_n  (rst_n),
        .bubble (ex_bubble),
        .d      (of_t),
        .q      (ex_t)
    );

    riscv_tag_stage u_ma (
        .clk    (clk),
        .rst_n  (rst_n),
        .bubble (1'b0),
        .d      (ex_t),
        .q      (ma_t)
    );

    riscv_tag_stage u_rw (
        .clk    (clk),
        .rst_n  (rst_n),
        .bubble (1'b0),
        .d      (ma_t),
        .q      (rw_t)
    );

    // Base already forwarded from MA while in EX: the same
    // producer is now in RW and must not forward twice.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ma_rs1_cov <= 1'b0;
        end else begin
            ma_rs1_cov <= mem1;
        end
    end

    always_comb begin
        ma_wr = writes_rd(ma_t) && !ma_t.isLd;
        rw_wr = writes_rd(rw_t);

        mem1 = ma_wr && reads_rs1(ex_t.a)
            && (ma_t.a.rd == ex_t.a.rs1);
        mem2 = ma_wr && reads_rs2(ex_t.a)
            && (ma_t.a.rd == ex_t.a.rs2);

        wb1 = rw_wr && reads_rs1(ex_t.a)
            && (rw_t.a.rd == ex_t.a.rs1) && !mem1;
        wb2 = rw_wr && reads_rs2(ex_t.a)
            && (rw_t.a.rd == ex_t.a.rs2) && !mem2;

        wbm2 = rw_wr && ma_t.a.valid && ma_t.isSt
            && (rw_t.a.rd == ma_t.a.rd);
        wbm1 = rw_wr && ma_t.a.valid
            && (ma_t.isLd || ma_t.isSt)
            && (rw_t.a.rd == ma_t.a.rs1) && !ma_rs1_cov;

        dd1 = rw_wr && reads_rs1(of_addr)
            && (rw_t.a.rd == of_addr.rs1);
        dd2 = rw_wr && reads_rs2(of_addr)
            && (rw_t.a.rd == of_addr.rs2);

        // Store data (rd) is excluded: wb_mem supplies it in MA.
        ld_hit = ex_t.a.valid && ex_t.isLd && (
            (reads_rs1(of_addr) && (ex_t.a.rd == of_addr.rs1))
            || (reads_rs2(of_addr) && (ex_t.a.rd == of_addr.rs2)));

        fw        = '0;
        stall_if  = 1'b0;
        stall_of  = 1'b0;
        flush_of  = 1'b0;
        ex_bubble = 1'b0;

        if (rst_n) begin
            fw.mem_exec_rs1_conflict = mem1;
            fw.mem_exec_rs2_conflict = mem2;
            fw.wb_exec_rs1_conflict  = wb1;
            fw.wb_exec_rs2_conflict  = wb2;
            fw.wb_mem_rs1_conflict   = wbm1;
            fw.wb_mem_rs2_conflict   = wbm2;
            fw.wb_dd_rs1_conflict    = dd1;
            fw.wb_dd_rs2_conflict    = dd2;
            fw.mem_fw_result         = ma_result;
            fw.wb_fw_result          = rw_result;
        end

        unique case (1'b1)
            (rst_n && ex_branch_taken): begin
                flush_of  = 1'b1;
                ex_bubble = 1'b1;
            end
            (rst_n && !ex_branch_taken && ld_hit): begin
                fw.ld_use_conflict = 1'b1;
                stall_if           = 1'b1;
                stall_of           = 1'b1;
                ex_bubble          = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_riscv_hazard_fw_unit.sv
// Bench for the hazard/forwarding unit: directed scenarios
// plus random instruction streams against an instruction-level model.
module tb_riscv_hazard_fw_unit;
    import riscv_params_pkg::*;

    logic          clk = 1'b0;
    logic          rst_n;
    address_reg    of_addr;
    control_signal of_ctrl;
    logic          br;
    logic [31:0]   ma_result;
    logic [31:0]   rw_result;
    fw_sig         fw;
    logic          stall_if;
    logic          stall_of;
    logic          flush_of;
    logic          ex_bubble;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic       v;
        opcode_e    op;
        logic       ib;
        logic [3:0] rs1;
        logic [3:0] rs2;
        logic [3:0] rd;
        logic       mf;
    } ins_t;

    typedef struct packed {
        logic me1, me2, we1, we2, wm1, wm2, dd1, dd2, lu;
        logic st, fl, bub;
    } exp_t;

    ins_t m_ex, m_ma, m_rw, cur;

    riscv_hazard_fw_unit dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .of_addr         (of_addr),
        .of_ctrl         (of_ctrl),
        .ex_branch_taken (br),
        .ma_result       (ma_result),
        .rw_result       (rw_result),
        .fw              (fw),
        .stall_if        (stall_if),
        .stall_of        (stall_of),
        .flush_of        (flush_of),
        .ex_bubble       (ex_bubble)
    );

    always #5 clk = ~clk;

    function automatic logic writer(ins_t i);
        return i.v && (i.op inside {OP_ADD, OP_SUB, OP_MUL,
            OP_DIV, OP_MOD, OP_AND, OP_OR, OP_NOT, OP_MOV,
            OP_LSL, OP_LSR, OP_ASR, OP_LD, OP_CALL});
    endfunction

    function automatic logic src1(ins_t i);
        return i.v && (i.op inside {OP_ADD, OP_SUB, OP_MUL,
            OP_DIV, OP_MOD, OP_CMP, OP_AND, OP_OR, OP_LSL,
            OP_LSR, OP_ASR, OP_LD, OP_ST, OP_RET});
    endfunction

    function automatic logic src2(ins_t i);
        return i.v && !i.ib && (i.op inside {OP_ADD, OP_SUB,
            OP_MUL, OP_DIV, OP_MOD, OP_CMP, OP_AND, OP_OR,
            OP_LSL, OP_LSR, OP_ASR});
    endfunction

    function automatic ins_t mk(opcode_e op, logic ib,
        logic [3:0] s1, logic [3:0] s2, logic [3:0] d);
        ins_t i;
        i = '0;
        i.v = 1'b1;
        i.op = op;
        i.ib = ib;
        i.rs1 = s1;
        i.rs2 = s2;
        i.rd = (op == OP_CALL) ? 4'd15 : d;
        return i;
    endfunction

    function automatic ins_t rand_ins();
        ins_t i;
        logic [4:0] o;
        o = 5'($urandom_range(0, 20));
        i = mk(opcode_e'(o), 1'($urandom_range(0, 1)),
            4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)),
            4'($urandom_range(0, 3)));
        i.v = ($urandom_range(0, 9) != 0);
        return i;
    endfunction

    // Expected hazard view of the instructions now in OF/EX/MA/RW.
    function automatic exp_t predict(ins_t o, logic b);
        exp_t e;
        logic hz;
        e = '0;
        if (writer(m_ma) && m_ma.op != OP_LD) begin
            e.me1 = src1(m_ex) && m_ex.rs1 == m_ma.rd;
            e.me2 = src2(m_ex) && m_ex.rs2 == m_ma.rd;
        end
        if (writer(m_rw)) begin
            e.we1 = src1(m_ex) && m_ex.rs1 == m_rw.rd && !e.me1;
            e.we2 = src2(m_ex) && m_ex.rs2 == m_rw.rd && !e.me2;
            e.wm2 = m_ma.v && m_ma.op == OP_ST
                && m_ma.rd == m_rw.rd;
            e.wm1 = m_ma.v && (m_ma.op inside {OP_LD, OP_ST})
                && m_ma.rs1 == m_rw.rd && !m_ma.mf;
            e.dd1 = src1(o) && o.rs1 == m_rw.rd;
            e.dd2 = src2(o) && o.rs2 == m_rw.rd;
        end
        hz = m_ex.v && m_ex.op == OP_LD && (
            (src1(o) && o.rs1 == m_ex.rd)
            || (src2(o) && o.rs2 == m_ex.rd));
        if (b) begin
            e.fl = 1'b1;
            e.bub = 1'b1;
        end else if (hz) begin
            e.lu = 1'b1;
            e.st = 1'b1;
            e.bub = 1'b1;
        end
        return e;
    endfunction

    task automatic drive();
        of_addr = '{opcode: cur.op, I_bit: cur.ib, rs1: cur.rs1,
            rs2: cur.rs2, rd: cur.rd, valid: cur.v};
        of_ctrl = '0;
        of_ctrl.isWb = writer(cur);
        of_ctrl.isLd = (cur.op == OP_LD);
        of_ctrl.isSt = (cur.op == OP_ST);
        of_ctrl.isImmediate = cur.ib;
        of_ctrl.isCall = (cur.op == OP_CALL);
    endtask

    task automatic tick();
        exp_t e;
        @(posedge clk);
        e = predict(cur, br);
        m_rw = m_ma;
        m_ma = m_ex;
        m_ma.mf = e.me1;
        m_ex = e.bub ? '0 : cur;
        m_ex.mf = 1'b0;
        #1;
    endtask

    task automatic model_reset();
        m_ex = '0;
        m_ma = '0;
        m_rw = '0;
    endtask

    task automatic flush_pipe();
        br = 1'b0;
        cur = mk(OP_NOP, 1'b0, 4'd0, 4'd0, 4'd0);
        drive();
        repeat (3) tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        model_reset();
        cur = mk(OP_ADD, 1'b0, 4'd1, 4'd1, 4'd1);
        br = 1'b1;
        ma_result = 32'hDEAD_BEEF;
        rw_result = 32'h1234_5678;
        drive();
        #2;
        checks++;
        if (fw !== '0) begin
            errors++;
            $display("FAIL reset_fw got %h want 0", fw);
        end
        checks++;
        if ({stall_if, stall_of, flush_of, ex_bubble} !== 4'b0) begin
            errors++;
            $display("FAIL reset_ctl got %b want 0000",
                {stall_if, stall_of, flush_of, ex_bubble});
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        br = 1'b0;
        #1;
        flush_pipe();
    endtask

    task automatic test_mem_exec();
        cur = mk(OP_ADD, 1'b0, 4'd1, 4'd2, 4'd3);
        drive();
        tick();
        cur = mk(OP_SUB, 1'b0, 4'd3, 4'd5, 4'd4);
        drive();
        tick();
        @(negedge clk);
        checks++;
        if (fw.mem_exec_rs1_conflict !== 1'b1 || stall_if !== 1'b0) begin
            errors++;
            $display("FAIL mem_exec got me1=%b st=%b want 1 0",
                fw.mem_exec_rs1_conflict, stall_if);
        end
        flush_pipe();
    endtask

    task automatic test_wb_exec();
        cur = mk(OP_ADD, 1'b0, 4'd1, 4'd2, 4'd3);
        drive();
        tick();
        cur = mk(OP_NOP, 1'b0, 4'd0, 4'd0, 4'd0);
        drive();
        tick();
        cur = mk(OP_OR, 1'b0, 4'd3, 4'd3, 4'd6);
        drive();
        tick();
        @(negedge clk);
        checks++;
        if ({fw.wb_exec_rs1_conflict, fw.wb_exec_rs2_conflict,
             fw.mem_exec_rs1_conflict, fw.mem_exec_rs2_conflict}
             !== 4'b1100) begin
            errors++;
            $display("FAIL wb_exec got %b want 1100",
                {fw.wb_exec_rs1_conflict, fw.wb_exec_rs2_conflict,
                 fw.mem_exec_rs1_conflict, fw.mem_exec_rs2_conflict});
        end
        flush_pipe();
    endtask

    task automatic test_load_use();
        cur = mk(OP_LD, 1'b1, 4'd1, 4'd0, 4'd2);
        drive();
        tick();
        cur = mk(OP_ADD, 1'b0, 4'd2, 4'd2, 4'd5);
        drive();
        @(negedge clk);
        checks++;
        if ({stall_if, stall_of, ex_bubble, fw.ld_use_conflict}
            !== 4'b1111) begin
            errors++;
            $display("FAIL ld_use_stall got %b want 1111",
                {stall_if, stall_of, ex_bubble, fw.ld_use_conflict});
        end
        tick();
        @(negedge clk);
        checks++;
        if ({stall_if, stall_of, ex_bubble} !== 3'b000) begin
            errors++;
            $display("FAIL ld_use_release got %b want 000",
                {stall_if, stall_of, ex_bubble});
        end
        tick();
        @(negedge clk);
        checks++;
        if ({fw.wb_exec_rs1_conflict, fw.mem_exec_rs1_conflict}
            !== 2'b10) begin
            errors++;
            $display("FAIL ld_use_fwd got %b want 10",
                {fw.wb_exec_rs1_conflict, fw.mem_exec_rs1_conflict});
        end
        flush_pipe();
    endtask

    task automatic test_ld_st();
        cur = mk(OP_LD, 1'b1, 4'd1, 4'd0, 4'd2);
        drive();
        tick();
        cur = mk(OP_ST, 1'b1, 4'd7, 4'd0, 4'd2);
        drive();
        @(negedge clk);
        checks++;
        if ({stall_if, fw.ld_use_conflict} !== 2'b00) begin
            errors++;
            $display("FAIL ld_st_nostall got %b want 00",
                {stall_if, fw.ld_use_conflict});
        end
        tick();
        tick();
        @(negedge clk);
        checks++;
        if ({fw.wb_mem_rs2_conflict, fw.wb_mem_rs1_conflict}
            !== 2'b10) begin
            errors++;
            $display("FAIL ld_st_wbmem got %b want 10",
                {fw.wb_mem_rs2_conflict, fw.wb_mem_rs1_conflict});
        end
        flush_pipe();
    endtask

    task automatic test_flush_vs_ld();
        cur = mk(OP_LD, 1'b1, 4'd1, 4'd0, 4'd2);
        drive();
        tick();
        cur = mk(OP_LD, 1'b1, 4'd2, 4'd0, 4'd9);
        br = 1'b1;
        drive();
        @(negedge clk);
        checks++;
        if ({flush_of, ex_bubble, stall_if, stall_of,
             fw.ld_use_conflict} !== 5'b11000) begin
            errors++;
            $display("FAIL flush_win got %b want 11000",
                {flush_of, ex_bubble, stall_if, stall_of,
                 fw.ld_use_conflict});
        end
        tick();
        br = 1'b0;
        cur = mk(OP_ADD, 1'b0, 4'd9, 4'd9, 4'd1);
        drive();
        @(negedge clk);
        checks++;
        if ({fw.ld_use_conflict, stall_if, flush_of} !== 3'b000) begin
            errors++;
            $display("FAIL flush_bubble got %b want 000",
                {fw.ld_use_conflict, stall_if, flush_of});
        end
        flush_pipe();
    endtask

    task automatic test_reset_midop();
        repeat (3) begin
            cur = mk(OP_ADD, 1'b0, 4'd2, 4'd2, 4'd1);
            drive();
            tick();
        end
        cur = mk(OP_ADD, 1'b0, 4'd1, 4'd1, 4'd1);
        br = 1'b1;
        drive();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({fw, stall_if, stall_of, flush_of, ex_bubble} !== '0) begin
            errors++;
            $display("FAIL midop_reset got fw=%h ctl=%b want 0",
                fw, {stall_if, stall_of, flush_of, ex_bubble});
        end
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        br = 1'b0;
        cur = mk(OP_CMP, 1'b0, 4'd1, 4'd1, 4'd0);
        drive();
        #1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++;
            if (fw[2*INSTR_WIDTH +: 9] !== 9'b0 || stall_if !== 1'b0) begin
                errors++;
                $display("FAIL midop_after%0d got %b st=%b want 0",
                    k, fw[2*INSTR_WIDTH +: 9], stall_if);
            end
            tick();
        end
        flush_pipe();
    endtask

    task automatic test_random();
        exp_t e;
        logic hold;
        logic [11:0] got;
        logic [11:0] want;
        hold = 1'b0;
        for (int n = 0; n < 600; n++) begin
            if (!hold) cur = rand_ins();
            br = ($urandom_range(0, 7) == 0);
            ma_result = $urandom;
            rw_result = $urandom;
            drive();
            @(negedge clk);
            e = predict(cur, br);
            got = {fw.mem_exec_rs1_conflict, fw.mem_exec_rs2_conflict,
                fw.wb_exec_rs1_conflict, fw.wb_exec_rs2_conflict,
                fw.wb_mem_rs1_conflict, fw.wb_mem_rs2_conflict,
                fw.wb_dd_rs1_conflict, fw.wb_dd_rs2_conflict,
                fw.ld_use_conflict, stall_if && stall_of,
                flush_of, ex_bubble};
            want = {e.me1, e.me2, e.we1, e.we2, e.wm1, e.wm2,
                e.dd1, e.dd2, e.lu, e.st, e.fl, e.bub};
            checks++;
            if (got !== want || stall_if !== stall_of) begin
                errors++;
                $display("FAIL rand_flags n=%0d got %b want %b",
                    n, got, want);
            end
            checks++;
            if (fw.mem_fw_result !== ma_result
                || fw.wb_fw_result !== rw_result) begin
                errors++;
                $display("FAIL rand_result n=%0d got %h %h want %h %h",
                    n, fw.mem_fw_result, fw.wb_fw_result,
                    ma_result, rw_result);
            end
            hold = e.st;
            tick();
        end
        flush_pipe();
    endtask

    initial begin
        rst_n = 1'b0;
        br = 1'b0;
        ma_result = '0;
        rw_result = '0;
        cur = '0;
        drive();
        test_reset();
        test_mem_exec();
        test_wb_exec();
        test_load_use();
        test_ld_st();
        test_flush_vs_ld();
        test_reset_midop();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
